// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate response checker: op encodings, FSM states
// and the reference gate function.
package gate_check_pkg;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_XOR  = 2;
  localparam int unsigned OP_NAND = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reference output of the gate under test; unknown op codes behave as AND.
  function automatic logic gate_ref(input int unsigned op, input logic a, input logic b);
    case (op)
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      default: return a & b;
    endcase
  endfunction

endpackage

// File: rtl/gate_checker_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gate_checker.sv
// Checks handshaked {a,b,c} samples of a two-input gate against a reference
// function, counting vectors/mismatches and capturing the first failure.
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned OP          = 0,
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned REQ_COV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_vec,
  output logic             fail_seen,
  output logic [3:0]       cov_mask
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t state_q;
  state_t state_d;
  logic   clear;
  logic   accept;
  logic   mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the per-cycle run-control strobes.
  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    accept   = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        accept   = in_valid;
        mismatch = in_valid && (c != gate_ref(OP, a, b));
        if (in_valid && (vec_count == LAST_IDX)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (accept),
    .count (vec_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (mismatch),
    .count (err_count)
  );

  // First-failure capture uses the pre-increment vector count as the index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_idx <= '0;
      first_fail_vec <= '0;
      fail_seen      <= 1'b0;
    end else if (clear) begin
      first_fail_idx <= '0;
      first_fail_vec <= '0;
      fail_seen      <= 1'b0;
    end else if (mismatch && !fail_seen) begin
      first_fail_idx <= vec_count;
      first_fail_vec <= {a, b, c};
      fail_seen      <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cov_mask <= '0;
    end else if (clear) begin
      cov_mask <= '0;
    end else if (accept) begin
      cov_mask[{a, b}] <= 1'b1;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign in_ready = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign pass     = (state_q == ST_DONE) && (err_count == '0) &&
                    ((REQ_COV == 0) || (cov_mask == 4'hF));

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker: completed runs are compared against
// hand-computed results queued by the stimulus process.
module tb_gate_checker;

  typedef struct packed {
    logic       pass;
    logic [7:0] vec;
    logic [7:0] err;
    logic [7:0] ffi;
    logic [2:0] ffv;
    logic       fs;
    logic [3:0] cov;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_x = 1'b0;
  logic in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;

  logic       d0_ready, d0_busy, d0_done, d0_pass, d0_fs;
  logic [7:0] d0_vec, d0_err, d0_ffi;
  logic [2:0] d0_ffv;
  logic [3:0] d0_cov;
  logic       d1_ready, d1_busy, d1_done, d1_pass, d1_fs;
  logic [7:0] d1_vec, d1_err, d1_ffi;
  logic [2:0] d1_ffv;
  logic [3:0] d1_cov;
  logic       d2_ready, d2_busy, d2_done, d2_pass, d2_fs;
  logic [7:0] d2_vec, d2_err, d2_ffi;
  logic [2:0] d2_ffv;
  logic [3:0] d2_cov;

  res_t act0, act1, act2;
  res_t q0[$], q1[$], q2[$];
  logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
  int checks = 0;
  int errors = 0;

  assign act0 = {d0_pass, d0_vec, d0_err, d0_ffi, d0_ffv, d0_fs, d0_cov};
  assign act1 = {d1_pass, d1_vec, d1_err, d1_ffi, d1_ffv, d1_fs, d1_cov};
  assign act2 = {d2_pass, d2_vec, d2_err, d2_ffi, d2_ffv, d2_fs, d2_cov};

  gate_checker #(.OP(0), .NUM_VECTORS(4), .CNT_W(8), .REQ_COV(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(d0_ready),
    .a(a), .b(b), .c(c), .busy(d0_busy), .done(d0_done), .pass(d0_pass),
    .vec_count(d0_vec), .err_count(d0_err), .first_fail_idx(d0_ffi),
    .first_fail_vec(d0_ffv), .fail_seen(d0_fs), .cov_mask(d0_cov));

  gate_checker #(.OP(0), .NUM_VECTORS(4), .CNT_W(8), .REQ_COV(0)) dut1 (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(d1_ready),
    .a(a), .b(b), .c(c), .busy(d1_busy), .done(d1_done), .pass(d1_pass),
    .vec_count(d1_vec), .err_count(d1_err), .first_fail_idx(d1_ffi),
    .first_fail_vec(d1_ffv), .fail_seen(d1_fs), .cov_mask(d1_cov));

  gate_checker #(.OP(2), .NUM_VECTORS(4), .CNT_W(8), .REQ_COV(1)) dut2 (
    .clk(clk), .rst(rst), .start(start_x), .in_valid(in_valid), .in_ready(d2_ready),
    .a(a), .b(b), .c(c), .busy(d2_busy), .done(d2_done), .pass(d2_pass),
    .vec_count(d2_vec), .err_count(d2_err), .first_fail_idx(d2_ffi),
    .first_fail_vec(d2_ffv), .fail_seen(d2_fs), .cov_mask(d2_cov));

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t act, input res_t exp);
    chk({tag, ".pass"}, 32'(act.pass), 32'(exp.pass));
    chk({tag, ".vec_count"}, 32'(act.vec), 32'(exp.vec));
    chk({tag, ".err_count"}, 32'(act.err), 32'(exp.err));
    chk({tag, ".first_fail_idx"}, 32'(act.ffi), 32'(exp.ffi));
    chk({tag, ".first_fail_vec"}, 32'(act.ffv), 32'(exp.ffv));
    chk({tag, ".fail_seen"}, 32'(act.fs), 32'(exp.fs));
    chk({tag, ".cov_mask"}, 32'(act.cov), 32'(exp.cov));
  endtask

  // Monitor: each rising edge of done pops one expected run result.
  always @(negedge clk) begin
    if (d0_done && !p0) begin
      if (q0.size() == 0) chk("dut0 unexpected done", 32'd1, 32'd0);
      else check_res("dut0", act0, q0.pop_front());
    end
    if (d1_done && !p1) begin
      if (q1.size() == 0) chk("dut1 unexpected done", 32'd1, 32'd0);
      else check_res("dut1", act1, q1.pop_front());
    end
    if (d2_done && !p2) begin
      if (q2.size() == 0) chk("dut2 unexpected done", 32'd1, 32'd0);
      else check_res("dut2", act2, q2.pop_front());
    end
    p0 <= d0_done;
    p1 <= d1_done;
    p2 <= d2_done;
  end

  task automatic start_pulse(input bit xor_dut);
    @(posedge clk); #1;
    if (xor_dut) start_x = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_x = 1'b0;
  endtask

  // Drives four vectors (first in the MSBs); gaps insert invalid cycles
  // carrying a wrong AND response, optionally with a stray start.
  task automatic run_vecs(input logic [11:0] vv, input bit gaps, input bit mid_start);
    for (int i = 0; i < 4; i++) begin
      {a, b, c} = vv[11-3*i -: 3];
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (gaps && i < 3) begin
        {a, b, c} = 3'b110;
        in_valid = 1'b0;
        if (mid_start && i == 1) start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #12 rst = 1'b0;
    chk("reset vec_count", 32'(d0_vec), 32'd0);
    chk("reset busy/ready/done/pass", {28'd0, d0_busy, d0_ready, d0_done, d0_pass}, 32'd0);
    chk("reset fail regs", {20'd0, d0_ffi, d0_ffv, d0_fs}, 32'd0);
    chk("reset cov/err", {20'd0, d0_cov, d0_err}, 32'd0);

    // Samples in IDLE are ignored
    @(posedge clk); #1;
    {a, b, c} = 3'b110;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("idle vec_count", 32'(d0_vec), 32'd0);
    chk("idle err_count", 32'(d0_err), 32'd0);

    // Clean AND pass
    q0.push_back('{1'b1, 8'd4, 8'd0, 8'd0, 3'b000, 1'b0, 4'hF});
    q1.push_back('{1'b1, 8'd4, 8'd0, 8'd0, 3'b000, 1'b0, 4'hF});
    start_pulse(1'b0);
    chk("start busy", 32'(d0_busy), 32'd1);
    run_vecs({3'b111, 3'b000, 3'b100, 3'b010}, 1'b0, 1'b0);
    chk("clean done", 32'(d0_done), 32'd1);
    chk("clean in_ready low", 32'(d0_ready), 32'd0);

    // Single mismatch on third vector
    q0.push_back('{1'b0, 8'd4, 8'd1, 8'd2, 3'b101, 1'b1, 4'hF});
    q1.push_back('{1'b0, 8'd4, 8'd1, 8'd2, 3'b101, 1'b1, 4'hF});
    start_pulse(1'b0);
    run_vecs({3'b111, 3'b000, 3'b101, 3'b010}, 1'b0, 1'b0);
    chk("mismatch done", 32'(d0_done), 32'd1);

    // Coverage gap: only REQ_COV=0 instance passes
    q0.push_back('{1'b0, 8'd4, 8'd0, 8'd0, 3'b000, 1'b0, 4'b1001});
    q1.push_back('{1'b1, 8'd4, 8'd0, 8'd0, 3'b000, 1'b0, 4'b1001});
    start_pulse(1'b0);
    run_vecs({3'b111, 3'b111, 3'b000, 3'b000}, 1'b0, 1'b0);

    // Toggled in_valid with a stray start mid-run
    q0.push_back('{1'b1, 8'd4, 8'd0, 8'd0, 3'b000, 1'b0, 4'hF});
    q1.push_back('{1'b1, 8'd4, 8'd0, 8'd0, 3'b000, 1'b0, 4'hF});
    start_pulse(1'b0);
    run_vecs({3'b111, 3'b000, 3'b100, 3'b010}, 1'b1, 1'b1);
    chk("gapped done", 32'(d0_done), 32'd1);

    // Asynchronous reset after two accepts
    start_pulse(1'b0);
    {a, b, c} = 3'b111; in_valid = 1'b1;
    @(posedge clk); #1;
    {a, b, c} = 3'b000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre-reset vec_count", 32'(d0_vec), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async reset vec/cov", {20'd0, d0_vec, d0_cov}, 32'd0);
    chk("async reset busy/ready", {30'd0, d0_busy, d0_ready}, 32'd0);
    @(negedge clk) rst = 1'b0;
    q0.push_back('{1'b1, 8'd4, 8'd0, 8'd0, 3'b000, 1'b0, 4'hF});
    q1.push_back('{1'b1, 8'd4, 8'd0, 8'd0, 3'b000, 1'b0, 4'hF});
    start_pulse(1'b0);
    run_vecs({3'b010, 3'b100, 3'b000, 3'b111}, 1'b0, 1'b0);
    chk("post-reset done", 32'(d0_done), 32'd1);

    // XOR run, then restart together with a sample in DONE
    q2.push_back('{1'b1, 8'd4, 8'd0, 8'd0, 3'b000, 1'b0, 4'hF});
    start_pulse(1'b1);
    run_vecs({3'b000, 3'b011, 3'b101, 3'b110}, 1'b0, 1'b0);
    chk("xor done", 32'(d2_done), 32'd1);
    @(posedge clk); #1;
    start_x = 1'b1; in_valid = 1'b1; {a, b, c} = 3'b011;
    @(posedge clk); #1;
    start_x = 1'b0; in_valid = 1'b0;
    chk("restart vec_count", 32'(d2_vec), 32'd0);
    chk("restart busy", 32'(d2_busy), 32'd1);
    chk("restart cov_mask", 32'(d2_cov), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("dut0 pending runs", 32'(q0.size()), 32'd0);
    chk("dut1 pending runs", 32'(q1.size()), 32'd0);
    chk("dut2 pending runs", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
